rtc_cmd_sched: RTL
==================

Name: rtc_cmd_sched

Overview:
Command scheduler in front of the RTC clock core. It arbitrates configuration and readback commands from NUM_REQ requesters, for example the APB register file and the power/wakeup manager. It validates BCD fields and drives the core's one-cycle update strobes and data fields. It also serialises all accesses, so only one update strobe is ever active per cycle and no clock write lands on a day rollover.

Parameters:
NUM_REQ, 2, number of requesters (1..8)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
req_valid_i  in  NUM_REQ  per-requester command valid
req_op_i  in  3*NUM_REQ  per-requester opcode (rtc_cmd_pkg::op_e)
req_data_i  in  32*NUM_REQ  per-requester payload
req_ready_o  out  NUM_REQ  one-hot accept pulse
rsp_valid_o  out  NUM_REQ  one-hot response pulse to the issuing requester
rsp_err_o  out  1  response error flag, qualified by any rsp_valid_o
rsp_data_o  out  32  response data, qualified by any rsp_valid_o
clock_update_o  out  1  core clock write strobe
clock_o  out  22  BCD hh:mm:ss to core
init_sec_cnt_o  out  10  sub-second preset to core
alarm_update_clock_o  out  1  alarm clock write strobe
alarm_enable_o  out  1  alarm enable
alarm_mask_o  out  6  alarm field mask
alarm_clock_o  out  22  alarm hh:mm:ss
alarm_update_date_o  out  1  alarm date write strobe
alarm_date_o  out  32  alarm date {2'b0,yyyy14,3'b0,mm5,2'b0,dd6}
timer_update_o  out  1  timer write strobe
timer_enable_o  out  1  timer enable
timer_retrig_o  out  1  timer auto-retrigger
timer_target_o  out  17  timer target
clock_i  in  22  current core clock
timer_value_i  in  17  current core timer value
update_day_i  in  1  core day-rollover pulse

Behaviour:
- Reset (async, rst_i=1): FSM to IDLE; all outputs 0; round-robin pointer = NUM_REQ-1, so requester 0 wins first.
- Opcodes and payloads:
  - SET_CLOCK=0: data[21:0] clock, data[31:22] init_sec_cnt.
  - SET_ALARM_CLK=1: data[21:0] clock, data[29:24] mask, data[31] enable.
  - SET_ALARM_DATE=2: data is the alarm_date format.
  - SET_TIMER=3: data[16:0] target, data[30] retrig, data[31] enable.
  - RD_CLOCK=4, RD_TIMER=5.
  - Opcodes 6 and 7 are illegal.
- States: IDLE -> CHECK -> ISSUE -> SETTLE -> RESP -> IDLE.
- IDLE:
  - If any req_valid_i is set, grant the round-robin winner, searching from pointer+1 upward with wrap.
  - Pulse req_ready_o for the winner, latch op and data, update the pointer, go to CHECK. This is cycle T.
  - Requesters hold valid until ready.
- CHECK (T+1):
  - Evaluate validity; RD_* and SET_TIMER are always valid.
  - Illegal opcode or invalid BCD -> set err and jump to RESP. No strobe is issued and no core field changes.
- ISSUE (T+2): register the payload onto the core fields and pulse exactly one strobe for one cycle. RD_* issue no strobe.
- Day-rollover guard: for SET_CLOCK only, if update_day_i=1 in ISSUE, hold the strobe and stay in ISSUE until update_day_i=0.
- Data fields: hold their value after the strobe until the next write of the same type.
- SETTLE (T+3): one-cycle wait so the readback reflects the write.
- RESP (T+4): pulse rsp_valid_o for the granted index.
  - rsp_data_o = {10'b0,clock_i} for RD_CLOCK, {15'b0,timer_value_i} for RD_TIMER, else 0.
  - rsp_err_o = err.
- Nominal latency: accept-to-response 4 cycles, 5 or more when deferred. There is no response backpressure. The next grant is possible in the cycle after RESP.
- A requester deasserting valid before ready is not a legal protocol; the command is simply not accepted.
- Reset mid-command aborts it: no response, and any asserted strobe drops immediately.

Optional Feature:
- RTC_CMD_BCD_CHECK_EN, when defined, enables CHECK validation:
  - Clock and alarm clock: every nibble <=9, sec/min <=0x59, hours <=0x23, unused bits 0.
  - Alarm date: day 0x01..0x31 and month 0x01..0x12, both BCD.
- Undefined: CHECK only rejects illegal opcodes; all payloads pass through unchanged.
- FSM timing is identical in both builds.

Decomposition:
- Package rtc_cmd_pkg:
  - op_e enum (3 bits).
  - Payload bit-position localparams.
  - State enum.
  - Field widths CLK_W=22 and TMR_W=17.
- Sub-module rtc_bcd_check (combinational): given op and data, returns valid; instantiated once in CHECK.
- The round-robin arbiter stays inline.

Test Plan:
- Reset: every output is 0. Req0 RD_CLOCK with clock_i=22'h123456 -> ready@T, rsp_valid_o[0]@T+4, rsp_data_o=0x00123456, rsp_err_o=0.
- Req1 SET_CLOCK data=0x0D412345: clock_update_o high for exactly one cycle @T+2, clock_o=0x012345, init_sec_cnt_o=0x035; rsp_err_o=0 @T+4.
- Same SET_CLOCK with update_day_i high at T+2 and T+3 -> strobe @T+4, response @T+6.
- Both requesters valid continuously with SET_TIMER -> grants alternate 0,1,0,1. Each timer_update_o pulse carries the matching target, e.g. 0x00100 then 0x1FFFF.
- SET_ALARM_CLK clock=0x006000 (bad minutes) with RTC_CMD_BCD_CHECK_EN -> no strobe, rsp_err_o=1. Without the macro -> strobe issued, alarm_clock_o=0x006000.
- rst_i asserted during ISSUE of SET_ALARM_DATE -> alarm_update_date_o drops asynchronously and no rsp_valid_o follows. After reset release, requester 0 is granted first.

Source files
------------

// File: rtl/rtc_cmd_pkg.sv
// rtl/rtc_cmd_pkg.sv - shared opcodes, states, payload layout and BCD helpers for rtc_cmd_sched
package rtc_cmd_pkg;

  localparam int CLK_W        = 22;
  localparam int TMR_W        = 17;
  localparam int INIT_LSB     = 22;
  localparam int INIT_W       = 10;
  localparam int ALM_MASK_LSB = 24;
  localparam int ALM_MASK_W   = 6;
  localparam int RETRIG_BIT   = 30;
  localparam int EN_BIT       = 31;

  typedef enum logic [2:0] {
    OP_SET_CLOCK      = 3'd0,
    OP_SET_ALARM_CLK  = 3'd1,
    OP_SET_ALARM_DATE = 3'd2,
    OP_SET_TIMER      = 3'd3,
    OP_RD_CLOCK       = 3'd4,
    OP_RD_TIMER       = 3'd5,
    OP_ILL6           = 3'd6,
    OP_ILL7           = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_SETTLE,
    ST_RESP
  } state_e;

  function automatic logic bcd_le(input logic [7:0] v, input logic [7:0] max);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max);
  endfunction

  // Clock layout is {hh[21:16], mm[15:8], ss[7:0]}.
  function automatic logic clock_ok(input logic [CLK_W-1:0] c);
    return bcd_le({2'b00, c[21:16]}, 8'h23) && bcd_le(c[15:8], 8'h59) && bcd_le(c[7:0], 8'h59);
  endfunction

endpackage

// File: rtl/rtc_bcd_check.sv
// rtl/rtc_bcd_check.sv - command payload validator; full BCD checks only when RTC_CMD_BCD_CHECK_EN is defined
module rtc_bcd_check
  import rtc_cmd_pkg::*;
(
  input  op_e         op_i,
  input  logic [31:0] data_i,
  output logic        valid_o
);

  logic unused_data;
  assign unused_data = ^data_i;

`ifdef RTC_CMD_BCD_CHECK_EN
  always_comb begin
    valid_o = 1'b0;
    case (op_i)
      OP_SET_CLOCK:      valid_o = clock_ok(data_i[CLK_W-1:0]);
      OP_SET_ALARM_CLK:  valid_o = clock_ok(data_i[CLK_W-1:0]) && (data_i[23:22] == 2'b00)
                                   && !data_i[RETRIG_BIT];
      OP_SET_ALARM_DATE: valid_o = bcd_le({2'b00, data_i[5:0]}, 8'h31) && (data_i[5:0] != 6'd0)
                                   && bcd_le({3'b000, data_i[12:8]}, 8'h12) && (data_i[12:8] != 5'd0);
      OP_SET_TIMER,
      OP_RD_CLOCK,
      OP_RD_TIMER:       valid_o = 1'b1;
      default:           valid_o = 1'b0;
    endcase
  end
`else
  assign valid_o = (op_i != OP_ILL6) && (op_i != OP_ILL7);
`endif

endmodule

// File: rtl/rtc_cmd_sched.sv
// rtl/rtc_cmd_sched.sv - round-robin command scheduler for the RTC core (BCD validation via RTC_CMD_BCD_CHECK_EN)
module rtc_cmd_sched
  import rtc_cmd_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [3*NUM_REQ-1:0]   req_op_i,
  input  logic [32*NUM_REQ-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [NUM_REQ-1:0]     rsp_valid_o,
  output logic                   rsp_err_o,
  output logic [31:0]            rsp_data_o,
  output logic                   clock_update_o,
  output logic [CLK_W-1:0]       clock_o,
  output logic [INIT_W-1:0]      init_sec_cnt_o,
  output logic                   alarm_update_clock_o,
  output logic                   alarm_enable_o,
  output logic [ALM_MASK_W-1:0]  alarm_mask_o,
  output logic [CLK_W-1:0]       alarm_clock_o,
  output logic                   alarm_update_date_o,
  output logic [31:0]            alarm_date_o,
  output logic                   timer_update_o,
  output logic                   timer_enable_o,
  output logic                   timer_retrig_o,
  output logic [TMR_W-1:0]       timer_target_o,
  input  logic [CLK_W-1:0]       clock_i,
  input  logic [TMR_W-1:0]       timer_value_i,
  input  logic                   update_day_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d, idx_q, idx_d;
  op_e                   op_q, op_d;
  logic [31:0]           data_q, data_d;
  logic                  err_q, err_d;
  logic [CLK_W-1:0]      clock_q, clock_d, alm_clk_q, alm_clk_d;
  logic [INIT_W-1:0]     init_sec_q, init_sec_d;
  logic                  alm_en_q, alm_en_d;
  logic [ALM_MASK_W-1:0] alm_mask_q, alm_mask_d;
  logic [31:0]           alm_date_q, alm_date_d;
  logic                  tmr_en_q, tmr_en_d, tmr_retrig_q, tmr_retrig_d;
  logic [TMR_W-1:0]      tmr_tgt_q, tmr_tgt_d;

  logic                  gnt_found;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  cmd_ok;
  logic                  day_hold;

  rtc_bcd_check u_bcd_check (
    .op_i    (op_q),
    .data_i  (data_q),
    .valid_o (cmd_ok)
  );

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    int c;
    c         = 0;
    gnt_found = 1'b0;
    gnt_idx   = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      c = int'(ptr_q) + 1 + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!gnt_found && req_valid_i[IDX_W'(c)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(c);
      end
    end
  end

  // A clock write must not coincide with the core's own day rollover.
  assign day_hold = (op_q == OP_SET_CLOCK) && update_day_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      ptr_q        <= IDX_W'(NUM_REQ - 1);
      idx_q        <= '0;
      op_q         <= OP_SET_CLOCK;
      data_q       <= '0;
      err_q        <= 1'b0;
      clock_q      <= '0;
      init_sec_q   <= '0;
      alm_en_q     <= 1'b0;
      alm_mask_q   <= '0;
      alm_clk_q    <= '0;
      alm_date_q   <= '0;
      tmr_en_q     <= 1'b0;
      tmr_retrig_q <= 1'b0;
      tmr_tgt_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      op_q         <= op_d;
      data_q       <= data_d;
      err_q        <= err_d;
      clock_q      <= clock_d;
      init_sec_q   <= init_sec_d;
      alm_en_q     <= alm_en_d;
      alm_mask_q   <= alm_mask_d;
      alm_clk_q    <= alm_clk_d;
      alm_date_q   <= alm_date_d;
      tmr_en_q     <= tmr_en_d;
      tmr_retrig_q <= tmr_retrig_d;
      tmr_tgt_q    <= tmr_tgt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    op_d         = op_q;
    data_d       = data_q;
    err_d        = err_q;
    clock_d      = clock_q;
    init_sec_d   = init_sec_q;
    alm_en_d     = alm_en_q;
    alm_mask_d   = alm_mask_q;
    alm_clk_d    = alm_clk_q;
    alm_date_d   = alm_date_q;
    tmr_en_d     = tmr_en_q;
    tmr_retrig_d = tmr_retrig_q;
    tmr_tgt_d    = tmr_tgt_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          idx_d   = gnt_idx;
          ptr_d   = gnt_idx;
          op_d    = op_e'(req_op_i[3*gnt_idx +: 3]);
          data_d  = req_data_i[32*gnt_idx +: 32];
          err_d   = 1'b0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!cmd_ok) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          state_d = ST_ISSUE;
          // Fields land together with the first ISSUE cycle and then hold.
          case (op_q)
            OP_SET_CLOCK: begin
              clock_d    = data_q[CLK_W-1:0];
              init_sec_d = data_q[INIT_LSB +: INIT_W];
            end
            OP_SET_ALARM_CLK: begin
              alm_clk_d  = data_q[CLK_W-1:0];
              alm_mask_d = data_q[ALM_MASK_LSB +: ALM_MASK_W];
              alm_en_d   = data_q[EN_BIT];
            end
            OP_SET_ALARM_DATE: alm_date_d = data_q;
            OP_SET_TIMER: begin
              tmr_tgt_d    = data_q[TMR_W-1:0];
              tmr_retrig_d = data_q[RETRIG_BIT];
              tmr_en_d     = data_q[EN_BIT];
            end
            default: ;
          endcase
        end
      end
      ST_ISSUE:  if (!day_hold) state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o          = '0;
    rsp_valid_o          = '0;
    rsp_err_o            = 1'b0;
    rsp_data_o           = '0;
    clock_update_o       = 1'b0;
    alarm_update_clock_o = 1'b0;
    alarm_update_date_o  = 1'b0;
    timer_update_o       = 1'b0;
    if (state_q == ST_IDLE && gnt_found && !rst_i) req_ready_o = NUM_REQ'(1) << gnt_idx;
    if (state_q == ST_ISSUE && !day_hold) begin
      clock_update_o       = (op_q == OP_SET_CLOCK);
      alarm_update_clock_o = (op_q == OP_SET_ALARM_CLK);
      alarm_update_date_o  = (op_q == OP_SET_ALARM_DATE);
      timer_update_o       = (op_q == OP_SET_TIMER);
    end
    if (state_q == ST_RESP) begin
      rsp_valid_o = NUM_REQ'(1) << idx_q;
      rsp_err_o   = err_q;
      if (op_q == OP_RD_CLOCK) rsp_data_o = {10'b0, clock_i};
      if (op_q == OP_RD_TIMER) rsp_data_o = {15'b0, timer_value_i};
    end
  end

  assign clock_o        = clock_q;
  assign init_sec_cnt_o = init_sec_q;
  assign alarm_enable_o = alm_en_q;
  assign alarm_mask_o   = alm_mask_q;
  assign alarm_clock_o  = alm_clk_q;
  assign alarm_date_o   = alm_date_q;
  assign timer_enable_o = tmr_en_q;
  assign timer_retrig_o = tmr_retrig_q;
  assign timer_target_o = tmr_tgt_q;

endmodule
